// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front-end with a small PC/instruction
// FIFO, credit-limited request issue and redirect-driven flush of in-flight words.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;
    localparam logic [UW-1:0] CREDITS = UW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] inflight_next;
    logic [UW-1:0] used;
    logic [31:0]   redirect_base;
    logic          handshake;
    logic          resp_ok;
    logic          push;
    logic          pop;

    assign used          = {1'b0, count} + {1'b0, inflight};
    assign redirect_base = redirect_pc & ~32'h3;

    assign req_valid   = !rst && !redirect && (used < CREDITS);
    assign req_addr    = fetch_pc;
    assign handshake   = req_valid && req_ready;

    // Responses with nothing outstanding are protocol violations and are ignored.
    assign resp_ok     = resp_valid && (inflight != '0);
    assign push        = resp_ok && !redirect && (discard == '0);
    assign pop         = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    // Outstanding-request count after this cycle's accepted request and response.
    always_comb begin
        inflight_next = inflight;
        if (handshake && !resp_ok) begin
            inflight_next = inflight + CW'(1);
        end else if (!handshake && resp_ok) begin
            inflight_next = inflight - CW'(1);
        end
    end

    // Fetch/response PCs, FIFO pointers, occupancy and discard bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old path.
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight_next;
            discard  <= inflight_next;
        end else begin
            inflight <= inflight_next;
            if (handshake) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp_ok && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage: cleared on reset, written with {resp_pc, resp_data} on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue with an in-order variable
// latency memory and a queue-based reference model of the fetch front-end.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    // reference model state
    ent_t        mq[$];
    int          m_inflight;
    int          m_discard;
    logic [31:0] m_fetch;
    logic [31:0] m_resp;

    // memory environment
    mreq_t memq[$];
    int    cyc;

    // stimulus knobs (percent probabilities, latency range)
    int          p_ready, p_reqrdy, p_gate, p_redir, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_pc;
    int          n_hs;

    int errors;
    int checks;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // one clock cycle: drive, compare at negedge, advance model and memory
    task automatic step(input bit do_rst);
        logic  exp_rv;
        logic  exp_iv;
        logic  hs_dut;
        bit    resp_ok;
        mreq_t r;
        rst         = do_rst;
        instr_ready = ($urandom_range(99) < p_ready);
        req_ready   = ($urandom_range(99) < p_reqrdy);
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else begin
            redirect    = ($urandom_range(99) < p_redir);
            redirect_pc = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(1023));
        end
        resp_valid = 1'b0;
        resp_data  = $urandom;
        if (!do_rst && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < p_gate) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(memq[0].addr);
        end

        @(negedge clk);
        exp_rv = !do_rst && !redirect && (mq.size() + m_inflight < DEPTH);
        exp_iv = (mq.size() != 0);
        check("req_valid", req_valid, exp_rv);
        if (!do_rst) begin
            check("req_addr", req_addr, m_fetch);
            check("instr_valid", instr_valid, exp_iv);
            if (exp_iv) begin
                check("instr", instr, mq[0].ins);
                check("instr_pc", instr_pc, mq[0].pc);
            end
        end

        hs_dut = req_valid && req_ready;
        if (hs_dut) n_hs++;
        if (resp_valid) r = memq.pop_front();
        if (hs_dut) memq.push_back('{addr: req_addr, due: cyc + $urandom_range(lat_max, lat_min)});

        if (do_rst) begin
            mq.delete();
            memq.delete();
            m_inflight = 0;
            m_discard  = 0;
            m_fetch    = RPC;
            m_resp     = RPC;
        end else begin
            resp_ok = resp_valid && (m_inflight > 0);
            if (redirect) begin
                if (resp_ok) m_inflight--;
                mq.delete();
                m_fetch   = {redirect_pc[31:2], 2'b00};
                m_resp    = {redirect_pc[31:2], 2'b00};
                m_discard = m_inflight;
            end else begin
                if (exp_iv && instr_ready) void'(mq.pop_front());
                if (resp_ok) begin
                    m_inflight--;
                    if (m_discard > 0) begin
                        m_discard--;
                    end else begin
                        mq.push_back('{pc: m_resp, ins: mem_word(m_resp)});
                        m_resp = m_resp + 32'd4;
                    end
                end
                if (exp_rv && req_ready) begin
                    m_fetch = m_fetch + 32'd4;
                    m_inflight++;
                end
            end
        end

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic knobs(input int rdy, input int rrdy, input int gate, input int redir,
                         input int lmin, input int lmax);
        p_ready = rdy; p_reqrdy = rrdy; p_gate = gate; p_redir = redir;
        lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        logic [31:0] seen[$];
        bit          found;
        errors = 0; checks = 0; cyc = 0; n_hs = 0;
        force_redir = 1'b0; force_pc = '0;
        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        knobs(100, 100, 100, 0, 1, 1);

        // reset values
        repeat (2) step(1'b1);
        check("rst_ivalid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr", req_addr, RPC);

        // stream with 1-cycle memory: first instr at cycle 2 after release
        step(1'b0);
        step(1'b0);
        check("lat_first_valid", instr_valid, 1'b1);
        check("lat_first_pc", instr_pc, RPC);
        repeat (20) step(1'b0);

        // backpressure from fresh reset
        step(1'b1);
        knobs(0, 100, 100, 0, 1, 1);
        n_hs = 0;
        repeat (10) step(1'b0);
        check("bp_reqs", n_hs, DEPTH);
        check("bp_stall", req_valid, 1'b0);
        check("bp_head", instr_pc, 32'h0);
        knobs(100, 100, 100, 0, 1, 1);
        repeat (10) step(1'b0);

        // redirect with three requests in flight on 3-cycle memory
        knobs(100, 100, 100, 0, 3, 3);
        repeat (8) step(1'b0);
        force_redir = 1'b1; force_pc = 32'h100;
        step(1'b0);
        check("redir_flush", instr_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (instr_valid) begin
                found = 1'b1;
                check("redir_first_pc", instr_pc, 32'h100);
            end else begin
                step(1'b0);
            end
        end
        if (!found) check("redir_timeout", 32'h0, 32'h1);
        repeat (10) step(1'b0);

        // misaligned redirect coinciding with a response and a pop
        knobs(100, 100, 100, 0, 1, 1);
        repeat (6) step(1'b0);
        force_redir = 1'b1; force_pc = 32'h203;
        step(1'b0);
        check("mis_addr", req_addr, 32'h200);
        check("mis_flush", instr_valid, 1'b0);
        repeat (6) step(1'b0);

        // address wrap-around
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        step(1'b0);
        seen.delete();
        for (int i = 0; i < 30 && seen.size() < 4; i++) begin
            step(1'b0);
            if (instr_valid && instr_ready) seen.push_back(instr_pc);
        end
        if (seen.size() == 4) begin
            check("wrap0", seen[0], 32'hFFFF_FFF8);
            check("wrap1", seen[1], 32'hFFFF_FFFC);
            check("wrap2", seen[2], 32'h0000_0000);
            check("wrap3", seen[3], 32'h0000_0004);
        end else begin
            check("wrap_timeout", 32'(seen.size()), 32'd4);
        end

        // reset mid-stream with a partly filled FIFO
        knobs(0, 100, 100, 0, 1, 1);
        repeat (3) step(1'b0);
        step(1'b1);
        check("mrst_ivalid", instr_valid, 1'b0);
        check("mrst_addr", req_addr, RPC);
        knobs(100, 100, 100, 0, 1, 1);
        repeat (8) step(1'b0);

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            int lmin;
            lmin = int'($urandom_range(4, 1));
            knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 40)), int'($urandom_range(10)),
                  lmin, lmin + int'($urandom_range(4)));
            if ($urandom_range(9) == 0) step(1'b1);
            repeat (60) step(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
